// File: rtl/ics_seq_pkg.sv
// Shared types and helpers for the ICS part sequencer: state encoding,
// per-part configuration record and IN_BUF word-count arithmetic.
package ics_seq_pkg;

    localparam int IN_BUF_DEPTH = 32;
    localparam int WORD_BITS    = 128;
    localparam int WORD_SHIFT   = $clog2(WORD_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHK   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic        en;
        logic [10:0] n;
        logic [13:0] e;
        logic [13:0] l;
        logic [13:0] st;
    } part_cfg_t;

    // Number of IN_BUF words needed to hold n input bits (ceiling divide).
    function automatic logic [4:0] words_of(input logic [10:0] n);
        logic [11:0] rounded;
        rounded = {1'b0, n} + 12'(WORD_BITS - 1);
        return 5'(rounded >> WORD_SHIFT);
    endfunction

endpackage

// File: rtl/ics_cfg_chk.sv
// Combinational validation of a latched three-part configuration; also
// derives each part's IN_BUF word count and packed base address.
module ics_cfg_chk
    import ics_seq_pkg::*;
(
    input  part_cfg_t   cfg0,
    input  part_cfg_t   cfg1,
    input  part_cfg_t   cfg2,
    output logic        err,
    output logic [4:0]  w0,
    output logic [4:0]  w1,
    output logic [4:0]  w2,
    output logic [4:0]  base0,
    output logic [4:0]  base1,
    output logic [4:0]  base2
);

    logic [5:0] total_s;

    function automatic logic part_bad(input part_cfg_t p);
        logic [14:0] span;
        span = {1'b0, p.st} + {1'b0, p.l};
        return p.en && ((p.n == 11'd0) || (p.l > p.e) || (span > {1'b0, p.e}));
    endfunction

    // Word counts, back-to-back base addresses and overall rejection.
    always_comb begin
        w0      = cfg0.en ? words_of(cfg0.n) : 5'd0;
        w1      = cfg1.en ? words_of(cfg1.n) : 5'd0;
        w2      = cfg2.en ? words_of(cfg2.n) : 5'd0;
        base0   = 5'd0;
        base1   = w0;
        base2   = 5'({1'b0, w0} + {1'b0, w1});
        total_s = {1'b0, w0} + {1'b0, w1} + {1'b0, w2};
        err     = !(cfg0.en || cfg1.en || cfg2.en)
                  || part_bad(cfg0) || part_bad(cfg1) || part_bad(cfg2)
                  || (total_s > 6'(IN_BUF_DEPTH));
    end

endmodule

// File: rtl/ics_part_seq.sv
// ICS part sequencer: latches a three-part configuration on ics_start and runs
// the enabled parts through the shared engine in ascending order.
module ics_part_seq
    import ics_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ics_start,
    input  logic        ics_part0_en,
    input  logic [10:0] ics_part0_n_size,
    input  logic [13:0] ics_part0_e_size,
    input  logic [13:0] ics_part0_l_size,
    input  logic [13:0] ics_part0_st_idx,
    input  logic        ics_part1_en,
    input  logic [10:0] ics_part1_n_size,
    input  logic [13:0] ics_part1_e_size,
    input  logic [13:0] ics_part1_l_size,
    input  logic [13:0] ics_part1_st_idx,
    input  logic        ics_part2_en,
    input  logic [10:0] ics_part2_n_size,
    input  logic [13:0] ics_part2_e_size,
    input  logic [13:0] ics_part2_l_size,
    input  logic [13:0] ics_part2_st_idx,
    output logic        eng_start,
    output logic [1:0]  eng_part_id,
    output logic [10:0] eng_n_size,
    output logic [13:0] eng_e_size,
    output logic [13:0] eng_l_size,
    output logic [13:0] eng_st_idx,
    output logic [4:0]  eng_base_addr,
    input  logic        eng_done,
    output logic        ics_busy,
    output logic        ics_done,
    output logic        ics_cfg_err
);

    seq_state_e  state_q, state_d;
    part_cfg_t   cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
    part_cfg_t   in0_s, in1_s, in2_s;
    logic        pend_q, pend_d;
    logic        eng_start_q, eng_start_d;
    logic [1:0]  part_id_q, part_id_d;
    logic [10:0] n_q, n_d;
    logic [13:0] e_q, e_d, l_q, l_d, st_q, st_d;
    logic [4:0]  base_q, base_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;

    logic        chk_err_s;
    logic [4:0]  w0_s, w1_s, w2_s, base0_s, base1_s, base2_s;
    logic [2:0]  active_s;
    logic        load_s;
    logic [1:0]  load_idx_s;
    logic        next_found_s;
    logic [1:0]  next_idx_s;

    assign in0_s = '{en: ics_part0_en, n: ics_part0_n_size, e: ics_part0_e_size,
                     l: ics_part0_l_size, st: ics_part0_st_idx};
    assign in1_s = '{en: ics_part1_en, n: ics_part1_n_size, e: ics_part1_e_size,
                     l: ics_part1_l_size, st: ics_part1_st_idx};
    assign in2_s = '{en: ics_part2_en, n: ics_part2_n_size, e: ics_part2_e_size,
                     l: ics_part2_l_size, st: ics_part2_st_idx};

    ics_cfg_chk u_cfg_chk (
        .cfg0  (cfg0_q),
        .cfg1  (cfg1_q),
        .cfg2  (cfg2_q),
        .err   (chk_err_s),
        .w0    (w0_s),
        .w1    (w1_s),
        .w2    (w2_s),
        .base0 (base0_s),
        .base1 (base1_s),
        .base2 (base2_s)
    );

    // A validated enabled part always has N > 0, so a nonzero word count marks it runnable.
    assign active_s = {(w2_s != 5'd0), (w1_s != 5'd0), (w0_s != 5'd0)};

    // Next higher runnable part after the one currently issued.
    always_comb begin
        next_found_s = 1'b0;
        next_idx_s   = 2'd0;
        case (part_id_q)
            2'd0: begin
                if (active_s[1]) begin
                    next_found_s = 1'b1;
                    next_idx_s   = 2'd1;
                end else if (active_s[2]) begin
                    next_found_s = 1'b1;
                    next_idx_s   = 2'd2;
                end else begin
                    next_found_s = 1'b0;
                end
            end
            2'd1: begin
                if (active_s[2]) begin
                    next_found_s = 1'b1;
                    next_idx_s   = 2'd2;
                end else begin
                    next_found_s = 1'b0;
                end
            end
            default: next_found_s = 1'b0;
        endcase
    end

    // Sequencer next-state and output decisions.
    always_comb begin
        state_d     = state_q;
        cfg0_d      = cfg0_q;
        cfg1_d      = cfg1_q;
        cfg2_d      = cfg2_q;
        pend_d      = pend_q;
        eng_start_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        load_s      = 1'b0;
        load_idx_s  = 2'd0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                pend_d = 1'b0;
                if (ics_start) begin
                    cfg0_d  = in0_s;
                    cfg1_d  = in1_s;
                    cfg2_d  = in2_s;
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (chk_err_s) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    load_s      = 1'b1;
                    load_idx_s  = active_s[0] ? 2'd0 : (active_s[1] ? 2'd1 : 2'd2);
                    eng_start_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A done coincident with the start pulse is remembered for WAIT.
                pend_d  = eng_done;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (next_found_s) begin
                    load_s      = 1'b1;
                    load_idx_s  = next_idx_s;
                    eng_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine field registers: reloaded only when a part is selected, held otherwise.
    always_comb begin
        part_id_d = part_id_q;
        n_d       = n_q;
        e_d       = e_q;
        l_d       = l_q;
        st_d      = st_q;
        base_d    = base_q;
        if (load_s) begin
            part_id_d = load_idx_s;
            case (load_idx_s)
                2'd0: begin
                    n_d = cfg0_q.n; e_d = cfg0_q.e; l_d = cfg0_q.l; st_d = cfg0_q.st;
                    base_d = base0_s;
                end
                2'd1: begin
                    n_d = cfg1_q.n; e_d = cfg1_q.e; l_d = cfg1_q.l; st_d = cfg1_q.st;
                    base_d = base1_s;
                end
                default: begin
                    n_d = cfg2_q.n; e_d = cfg2_q.e; l_d = cfg2_q.l; st_d = cfg2_q.st;
                    base_d = base2_s;
                end
            endcase
        end else begin
            part_id_d = part_id_q;
        end
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg0_q      <= '0;
            cfg1_q      <= '0;
            cfg2_q      <= '0;
            pend_q      <= 1'b0;
            eng_start_q <= 1'b0;
            part_id_q   <= 2'd0;
            n_q         <= 11'd0;
            e_q         <= 14'd0;
            l_q         <= 14'd0;
            st_q        <= 14'd0;
            base_q      <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg0_q      <= cfg0_d;
            cfg1_q      <= cfg1_d;
            cfg2_q      <= cfg2_d;
            pend_q      <= pend_d;
            eng_start_q <= eng_start_d;
            part_id_q   <= part_id_d;
            n_q         <= n_d;
            e_q         <= e_d;
            l_q         <= l_d;
            st_q        <= st_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_part_id   = part_id_q;
    assign eng_n_size    = n_q;
    assign eng_e_size    = e_q;
    assign eng_l_size    = l_q;
    assign eng_st_idx    = st_q;
    assign eng_base_addr = base_q;
    assign ics_busy      = busy_q;
    assign ics_done      = done_q;
    assign ics_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_ics_part_seq.sv
// Directed, table-driven bench for ics_part_seq with an emulated engine that
// answers each eng_start with eng_done after a fixed latency.
module tb_ics_part_seq;

    logic        clk, rst_n, ics_start, eng_done;
    logic        ics_part0_en, ics_part1_en, ics_part2_en;
    logic [10:0] ics_part0_n_size, ics_part1_n_size, ics_part2_n_size;
    logic [13:0] ics_part0_e_size, ics_part1_e_size, ics_part2_e_size;
    logic [13:0] ics_part0_l_size, ics_part1_l_size, ics_part2_l_size;
    logic [13:0] ics_part0_st_idx, ics_part1_st_idx, ics_part2_st_idx;
    logic        eng_start, ics_busy, ics_done, ics_cfg_err;
    logic [1:0]  eng_part_id;
    logic [10:0] eng_n_size;
    logic [13:0] eng_e_size, eng_l_size, eng_st_idx;
    logic [4:0]  eng_base_addr;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    typedef struct {
        logic [2:0]        en;
        logic [2:0][10:0]  n;
        logic [2:0][13:0]  e;
        logic [2:0][13:0]  l;
        logic [2:0][13:0]  st;
        bit                err;
        int                nissue;
        logic [2:0][1:0]   id;
        logic [2:0][4:0]   base;
    } vec_t;

    vec_t vecs [9];

    ics_part_seq dut (
        .clk(clk), .rst_n(rst_n), .ics_start(ics_start),
        .ics_part0_en(ics_part0_en), .ics_part0_n_size(ics_part0_n_size),
        .ics_part0_e_size(ics_part0_e_size), .ics_part0_l_size(ics_part0_l_size),
        .ics_part0_st_idx(ics_part0_st_idx),
        .ics_part1_en(ics_part1_en), .ics_part1_n_size(ics_part1_n_size),
        .ics_part1_e_size(ics_part1_e_size), .ics_part1_l_size(ics_part1_l_size),
        .ics_part1_st_idx(ics_part1_st_idx),
        .ics_part2_en(ics_part2_en), .ics_part2_n_size(ics_part2_n_size),
        .ics_part2_e_size(ics_part2_e_size), .ics_part2_l_size(ics_part2_l_size),
        .ics_part2_st_idx(ics_part2_st_idx),
        .eng_start(eng_start), .eng_part_id(eng_part_id), .eng_n_size(eng_n_size),
        .eng_e_size(eng_e_size), .eng_l_size(eng_l_size), .eng_st_idx(eng_st_idx),
        .eng_base_addr(eng_base_addr), .eng_done(eng_done),
        .ics_busy(ics_busy), .ics_done(ics_done), .ics_cfg_err(ics_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int en, input int n0, n1, n2, input int e0, e1, e2,
                                input int l0, l1, l2, input int s0, s1, s2, input int err,
                                input int nis, input int i0, i1, i2, input int b0, b1, b2);
        vec_t v;
        v.en = 3'(en);
        v.n[0] = 11'(n0); v.n[1] = 11'(n1); v.n[2] = 11'(n2);
        v.e[0] = 14'(e0); v.e[1] = 14'(e1); v.e[2] = 14'(e2);
        v.l[0] = 14'(l0); v.l[1] = 14'(l1); v.l[2] = 14'(l2);
        v.st[0] = 14'(s0); v.st[1] = 14'(s1); v.st[2] = 14'(s2);
        v.err = (err != 0);
        v.nissue = nis;
        v.id[0] = 2'(i0); v.id[1] = 2'(i1); v.id[2] = 2'(i2);
        v.base[0] = 5'(b0); v.base[1] = 5'(b1); v.base[2] = 5'(b2);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        ics_part0_en = v.en[0]; ics_part0_n_size = v.n[0]; ics_part0_e_size = v.e[0];
        ics_part0_l_size = v.l[0]; ics_part0_st_idx = v.st[0];
        ics_part1_en = v.en[1]; ics_part1_n_size = v.n[1]; ics_part1_e_size = v.e[1];
        ics_part1_l_size = v.l[1]; ics_part1_st_idx = v.st[1];
        ics_part2_en = v.en[2]; ics_part2_n_size = v.n[2]; ics_part2_e_size = v.e[2];
        ics_part2_l_size = v.l[2]; ics_part2_st_idx = v.st[2];
    endtask

    // Called at a negedge; returns at a negedge (with ics_start left high if b2b).
    task automatic run_vec(input vec_t v, input bit poke_start, input bit rst_p1, input bit b2b);
        int c0;
        int pid;
        apply(v);
        c0 = start_cnt;
        ics_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ics_start = 1'b0;
        chk("chk_cycle_eng_start", eng_start, 0);
        chk("chk_cycle_busy", ics_busy, 0);
        @(negedge clk);
        if (v.err) begin
            chk("cfg_err_pulse", ics_cfg_err, 1);
            chk("cfg_err_eng_start", eng_start, 0);
            chk("cfg_err_busy", ics_busy, 0);
            @(negedge clk);
            chk("cfg_err_clear", ics_cfg_err, 0);
            chk("cfg_err_busy_after", ics_busy, 0);
            chk("cfg_err_no_issue", start_cnt - c0, 0);
            return;
        end
        chk("no_cfg_err", ics_cfg_err, 0);
        for (int j = 0; j < v.nissue; j++) begin
            pid = int'(v.id[j]);
            chk("issue_eng_start", eng_start, 1);
            chk("issue_busy", ics_busy, 1);
            chk("issue_part_id", eng_part_id, v.id[j]);
            chk("issue_base", eng_base_addr, v.base[j]);
            chk("issue_n", eng_n_size, v.n[pid]);
            chk("issue_e", eng_e_size, v.e[pid]);
            chk("issue_l", eng_l_size, v.l[pid]);
            chk("issue_st", eng_st_idx, v.st[pid]);
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                ics_start = (poke_start && j == 0 && w == 0) ? 1'b1 : 1'b0;
                if (rst_p1 && j == 1 && w == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_eng_start", eng_start, 0);
                    chk("rst_busy", ics_busy, 0);
                    chk("rst_part_id", eng_part_id, 0);
                    chk("rst_base", eng_base_addr, 0);
                    chk("rst_n_size", eng_n_size, 0);
                    chk("rst_done", ics_done, 0);
                    chk("rst_err", ics_cfg_err, 0);
                    chk("rst_issue_count", start_cnt - c0, 2);
                    @(negedge clk);
                    chk("rst_hold_done", ics_done, 0);
                    rst_n = 1'b1;
                    return;
                end
                chk("wait_eng_start", eng_start, 0);
                chk("wait_part_id", eng_part_id, v.id[j]);
                chk("wait_base", eng_base_addr, v.base[j]);
            end
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
            chk("next_eng_start", eng_start, 0);
            chk("next_ics_done", ics_done, 0);
            chk("next_busy", ics_busy, 1);
            @(negedge clk);
        end
        chk("ics_done_pulse", ics_done, 1);
        chk("ics_done_busy", ics_busy, 1);
        chk("issue_count", start_cnt - c0, v.nissue);
        if (b2b) begin
            ics_start = 1'b1;
            return;
        end
        @(negedge clk);
        chk("ics_done_clear", ics_done, 0);
        chk("busy_fall", ics_busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; ics_start = 1'b0; eng_done = 1'b0;
        vecs[0] = mk(3'b111, 300, 128, 1, 600, 256, 32, 600, 256, 32, 0, 0, 0, 0, 3, 0, 1, 2, 0, 3, 4);
        vecs[1] = mk(3'b101, 256, 0, 129, 300, 50, 200, 300, 60, 150, 0, 0, 50, 0, 2, 0, 2, 0, 0, 2, 0);
        vecs[2] = mk(3'b000, 300, 128, 1, 600, 256, 32, 600, 256, 32, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(3'b001, 64, 0, 0, 99, 0, 0, 100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(3'b001, 64, 0, 0, 100, 0, 0, 95, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(3'b111, 2047, 2047, 1, 100, 100, 100, 100, 100, 100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(3'b100, 0, 0, 128, 0, 0, 32, 0, 0, 28, 0, 0, 4, 0, 1, 2, 0, 0, 0, 0, 0);
        vecs[7] = mk(3'b011, 2047, 2047, 0, 100, 100, 0, 100, 100, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 16, 0);
        vecs[8] = mk(3'b010, 0, 0, 0, 0, 10, 0, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(vecs[0]);
        #3;
        chk("reset_eng_start", eng_start, 0);
        chk("reset_busy", ics_busy, 0);
        chk("reset_done", ics_done, 0);
        chk("reset_cfg_err", ics_cfg_err, 0);
        chk("reset_part_id", eng_part_id, 0);
        chk("reset_base", eng_base_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0, 1'b0, 1'b0);

        // Start re-pulsed during WAIT of part 0 must not disturb the run.
        run_vec(vecs[0], 1'b1, 1'b0, 1'b0);

        // eng_done while idle is ignored.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("idle_done_eng_start", eng_start, 0);
        chk("idle_done_busy", ics_busy, 0);
        @(negedge clk);
        chk("idle_done_ics_done", ics_done, 0);
        chk("idle_done_busy2", ics_busy, 0);
        run_vec(vecs[1], 1'b0, 1'b0, 1'b0);

        // Reset during part 1, then a clean run from part 0.
        run_vec(vecs[0], 1'b0, 1'b1, 1'b0);
        run_vec(vecs[0], 1'b0, 1'b0, 1'b0);

        // Back-to-back: new start sampled on the edge right after ics_done.
        run_vec(vecs[0], 1'b0, 1'b0, 1'b1);
        run_vec(vecs[7], 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ics_part_seq.md
# ics_part_seq

Sequencer for the ICS per-part processing engine. It accepts one `ics_start` pulse with the three-part configuration, validates it, and computes each part's IN_BUF base word address. It then runs the enabled parts through the shared interleave engine strictly in order part0 → part1 → part2, one part at a time, handshaking on `eng_start`/`eng_done`. It sits between the top-level ICS control inputs and the single interleaver/FILO-fill engine.

## Interface
- `IN_BUF_DEPTH`, 32, IN_BUF depth in 128-bit words; fixes the width of `eng_base_addr`.
- `WORD_BITS`, 128, IN_BUF word width in bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ics_start` input 1: single-cycle start pulse.
- `ics_partK_en` (K = 0, 1, 2) input 1: part K enable.
- `ics_partK_n_size` input 11: N_K, input bit length.
- `ics_partK_e_size` input 14: E_K, bit length after interleaving.
- `ics_partK_l_size` input 14: L_K, valid bit length.
- `ics_partK_st_idx` input 14: S_K, start index of the valid bits.
- `eng_start` output 1: single-cycle pulse that starts the engine on the current part.
- `eng_part_id` output 2: current part number, 0 to 2.
- `eng_n_size` output 11, `eng_e_size` output 14, `eng_l_size` output 14, `eng_st_idx` output 14: latched configuration of the current part.
- `eng_base_addr` output 5: IN_BUF word address of the current part's first word.
- `eng_done` input 1: single-cycle pulse from the engine when the current part is finished.
- `ics_busy` output 1: high from the cycle after an accepted start until the cycle `ics_done` is asserted.
- `ics_done` output 1: single-cycle pulse when all enabled parts are finished.
- `ics_cfg_err` output 1: single-cycle pulse when the configuration is rejected.

## Operation
- States are IDLE, CHK, ISSUE, WAIT, NEXT.
- **IDLE.**
  - `ics_start` high: latch all part fields, go to CHK.
  - Otherwise: stay in IDLE.
- **Word count and base addresses (CHK).**
  - Word count per part: W_K = (N_K + 127) >> 7, computed at 5 bits. W_K is 0 for a disabled part.
  - Base addresses: base0 = 0; base1 = W0; base2 = W0 + W1. The sum is computed at 6 bits.
- **Error conditions (CHK).** Any one of the following sets `ics_cfg_err` for one cycle and returns the block to IDLE with no `eng_start`:
  - no part enabled;
  - an enabled part with N = 0;
  - an enabled part with L > E;
  - an enabled part with S + L > E, computed at 15 bits;
  - W0 + W1 + W2 > IN_BUF_DEPTH.
- **Valid configuration (CHK).** Select the lowest enabled part, drive its `eng_*` fields, go to ISSUE.
- **ISSUE.** Assert `eng_start` for one cycle, go to WAIT.
- **WAIT.**
  - `eng_done` high: go to NEXT.
  - `eng_*` fields hold stable for the whole part.
- **NEXT.**
  - Another enabled part with a higher index exists: load the next higher enabled part's fields, go to ISSUE.
  - No such part: pulse `ics_done`, go to IDLE.
- `ics_start` outside IDLE is ignored.
- `eng_done` outside WAIT is ignored.
- `eng_done` arriving in the same cycle as ISSUE is treated as arriving in WAIT: it is latched and honoured.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. Reset mid-operation aborts immediately, with no `ics_done` and no `ics_cfg_err`.
- **Start sampled at edge k:**
  - state is CHK during cycle k+1;
  - `eng_start` and `ics_busy` rise at k+2;
  - on an error, `ics_cfg_err` is high during k+2 only and `ics_busy` stays 0.
- **`eng_done` sampled at edge m:**
  - NEXT during m+1;
  - the next `eng_start` at m+2, or `ics_done` at m+2 with `ics_busy` falling at m+3.
- Overhead per part is 2 cycles plus the engine latency.
- All outputs are registered.
- A new `ics_start` is accepted at the earliest on the edge after `ics_done`.

## Structure
- **`ics_seq_pkg` contents:**
  - state enum `seq_state_e`;
  - constants `IN_BUF_DEPTH` and `WORD_BITS`;
  - struct `part_cfg_t` with fields en, n, e, l, st;
  - function `words_of(n)`.
- **Sub-module `ics_cfg_chk`.** Combinational. Takes three `part_cfg_t`, returns `err`, W0 to W2 and the three base addresses. It is instantiated once, on the latched configuration.
- **FSM, counters and output registers** stay in `ics_part_seq`.

## Test plan
- **All three parts valid.** Start with N = (300, 128, 1), E = (600, 256, 32), L = E, S = 0.
  - Expected: three `eng_start` pulses with `eng_part_id` 0, 1, 2 and base addresses 0, 3, 4.
  - `ics_done` 2 cycles after the third `eng_done`.
- **Part 1 disabled.** Part0 N = 256, part2 N = 129.
  - Expected: `eng_part_id` 0 then 2, base addresses 0 then 2; no part1 issue.
- **Rejected configurations.** Each of the following gives `ics_cfg_err` at start + 2, no `eng_start`, and `ics_busy` remains 0:
  - no part enabled;
  - L = 100 > E = 99;
  - S = 10, L = 95, E = 100;
  - N = (2047, 2047, 1), 33 words.
- **Start while busy.** `ics_start` re-pulsed while in WAIT.
  - Expected: ignored, and the sequence is unchanged.
  - `eng_done` pulsed while in IDLE is likewise ignored.
- **Reset mid-run.** `rst_n` asserted during WAIT of part 1.
  - Expected: all outputs 0 at once; a new start then runs cleanly from part 0.
- **Back-to-back runs.** `ics_start` 1 cycle after `ics_done`.
  - Expected: accepted, with `eng_start` 2 cycles later.
